// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the parameterised serial receiver.
// Holds the receive FSM encoding and the parity-mode selector values.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/serial_receiver_param_if.sv
// Line, status and output-handshake signals of the serial receiver.
// The receiver takes the slave view; the line driver / word consumer takes master.
interface serial_receiver_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 in;
  logic                 out_ready;
  logic                 done;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun;

  modport master (
    output in, out_ready,
    input  done, out_data, out_valid, parity_err, framing_err, overrun
  );

  modport slave (
    input  in, out_ready,
    output done, out_data, out_valid, parity_err, framing_err, overrun
  );
endinterface

// File: rtl/serial_rx_out_buf.sv
// One-entry holding register for received words with valid/ready hand-off.
// A word arriving while the old one is still unconsumed is dropped and flagged.
module serial_rx_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // A consumer taking the old word on this same edge frees the slot.
        if (valid && !ready) begin
          overrun <= 1'b1;
        end else begin
          data  <= load_data;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_receiver_param.sv
// Parameterised serial frame receiver: start bit, DATA_BITS LSB-first data,
// optional parity, STOP_BITS stop bits, one line bit per clock.
module serial_receiver_param
  import serial_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input logic                   clk,
  input logic                   reset,
  serial_receiver_param_if.slave bus
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("serial_receiver_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN && PARITY_MODE != PARITY_ODD) begin : g_bad_parity
    $error("serial_receiver_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("serial_receiver_param: STOP_BITS must be 1..2");
  end

  localparam int                CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t               state, next_state;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bad;
  logic                 err_seen;
  logic                 last_stop;
  logic                 load;

  assign last_stop = (STOP_BITS == 1) || stop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: next_state = bus.in ? IDLE : DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT)
          next_state = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      end
      PARITY: next_state = STOP;
      STOP: begin
        if (!bus.in)        next_state = ERROR;
        else if (last_stop) next_state = DONE;
      end
      ERROR:   if (bus.in) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      parity_bad <= 1'b0;
      err_seen   <= 1'b0;
    end else begin
      bit_cnt  <= (state == DATA && bit_cnt != LAST_BIT) ? bit_cnt + 1'b1 : '0;
      stop_cnt <= (state == STOP) ? ~stop_cnt : 1'b0;
      err_seen <= (state == ERROR);
      if (state == DATA) begin
        shift_reg  <= {bus.in, shift_reg[DATA_BITS-1:1]};
        parity_bad <= 1'b0;
      end else if (state == PARITY) begin
        parity_bad <= ((^shift_reg) ^ bus.in) != (PARITY_MODE == PARITY_ODD);
      end
    end
  end

  always_comb begin
    bus.done        = (state == DONE);
    bus.parity_err  = (state == DONE) && parity_bad;
    bus.framing_err = (state == ERROR) && !err_seen;
    // The word is committed on the edge that accepts the final stop bit.
    load            = (state == STOP) && bus.in && last_stop && !parity_bad;
  end

  serial_rx_out_buf #(
    .WIDTH (DATA_BITS)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (shift_reg),
    .ready     (bus.out_ready),
    .data      (bus.out_data),
    .valid     (bus.out_valid),
    .overrun   (bus.overrun)
  );

endmodule

// File: tb/tb_serial_receiver_param.sv
// Bench for serial_receiver_param across four parameterisations sharing one clock.
module tb_serial_receiver_param;
  import serial_rx_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_receiver_param_if #(.DATA_BITS(8)) if0 ();
  serial_receiver_param_if #(.DATA_BITS(8)) if1 ();
  serial_receiver_param_if #(.DATA_BITS(8)) if2 ();
  serial_receiver_param_if #(.DATA_BITS(9)) if3 ();

  serial_receiver_param u0 (.clk(clk), .reset(reset), .bus(if0));
  serial_receiver_param #(.PARITY_MODE(PARITY_EVEN)) u1 (.clk(clk), .reset(reset), .bus(if1));
  serial_receiver_param #(.PARITY_MODE(PARITY_ODD), .STOP_BITS(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
  serial_receiver_param #(.DATA_BITS(9), .STOP_BITS(2)) u3 (.clk(clk), .reset(reset), .bus(if3));

  typedef struct packed {
    logic       done;
    logic       parity_err;
    logic       framing_err;
    logic       overrun;
    logic       out_valid;
    logic [8:0] out_data;
  } obs_t;

  int         checks   = 0;
  int         failures = 0;
  logic       mdl_valid [N];
  logic [8:0] mdl_data  [N];

  function automatic int db(input int sel);
    return (sel == 3) ? 9 : 8;
  endfunction

  function automatic int pm(input int sel);
    case (sel)
      1:       return PARITY_EVEN;
      2:       return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

  function automatic int sb(input int sel);
    return (sel >= 2) ? 2 : 1;
  endfunction

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    case (sel)
      0:       o = {if0.done, if0.parity_err, if0.framing_err, if0.overrun, if0.out_valid, 1'b0, if0.out_data};
      1:       o = {if1.done, if1.parity_err, if1.framing_err, if1.overrun, if1.out_valid, 1'b0, if1.out_data};
      2:       o = {if2.done, if2.parity_err, if2.framing_err, if2.overrun, if2.out_valid, 1'b0, if2.out_data};
      default: o = {if3.done, if3.parity_err, if3.framing_err, if3.overrun, if3.out_valid, if3.out_data};
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic set_in(input int sel, input logic b);
    case (sel)
      0:       if0.in = b;
      1:       if1.in = b;
      2:       if2.in = b;
      default: if3.in = b;
    endcase
  endtask

  task automatic set_ready(input int sel, input logic b);
    case (sel)
      0:       if0.out_ready = b;
      1:       if1.out_ready = b;
      2:       if2.out_ready = b;
      default: if3.out_ready = b;
    endcase
  endtask

  task automatic idle(input int n);
    for (int s = 0; s < N; s++) begin
      set_in(s, 1'b1);
      set_ready(s, 1'b0);
    end
    repeat (n) @(negedge clk);
  endtask

  // Drives one complete frame; bad_stop is the index of a zero stop bit, or -1.
  task automatic send_frame(input int sel, input logic [8:0] data, input bit bad_par,
                            input int bad_stop, input bit rdy, input string tag);
    logic bits [$];
    int   err_at;
    bit   par, good, load_exp, ovr_exp;
    obs_t o;
    err_at = -1;
    bits.push_back(1'b0);
    for (int i = 0; i < db(sel); i++) bits.push_back(data[i]);
    if (pm(sel) != PARITY_NONE) begin
      par = (pm(sel) == PARITY_EVEN) ? ^data : ~^data;
      bits.push_back(bad_par ? ~par : par);
    end
    for (int i = 0; i < sb(sel); i++) begin
      bits.push_back(i == bad_stop ? 1'b0 : 1'b1);
      if (i == bad_stop && err_at < 0) err_at = bits.size() - 1;
    end
    for (int i = 0; i < bits.size(); i++) begin
      if (i == bits.size() - 1) set_ready(sel, rdy);
      set_in(sel, bits[i]);
      @(negedge clk);
      o = get_obs(sel);
      if (i < bits.size() - 1) begin
        check({tag, "_done_mid"}, 32'(o.done), 32'(0));
        check({tag, "_framing_mid"}, 32'(o.framing_err), 32'(i == err_at));
      end
    end
    good     = (err_at < 0);
    load_exp = good && !(pm(sel) != PARITY_NONE && bad_par);
    ovr_exp  = load_exp && mdl_valid[sel] && !rdy;
    if (load_exp && !ovr_exp) begin
      mdl_valid[sel] = 1'b1;
      mdl_data[sel]  = data;
    end else if (!load_exp && mdl_valid[sel] && rdy) begin
      mdl_valid[sel] = 1'b0;
    end
    check({tag, "_done"}, 32'(o.done), 32'(good));
    check({tag, "_parity_err"}, 32'(o.parity_err), 32'(good && pm(sel) != PARITY_NONE && bad_par));
    check({tag, "_framing_err"}, 32'(o.framing_err), 32'(err_at == bits.size() - 1));
    check({tag, "_overrun"}, 32'(o.overrun), 32'(ovr_exp));
    check({tag, "_out_valid"}, 32'(o.out_valid), 32'(mdl_valid[sel]));
    check({tag, "_out_data"}, 32'(o.out_data), 32'(mdl_data[sel]));
    set_ready(sel, 1'b0);
  endtask

  task automatic consume(input int sel, input string tag);
    obs_t o;
    set_ready(sel, 1'b1);
    @(negedge clk);
    set_ready(sel, 1'b0);
    mdl_valid[sel] = 1'b0;
    o = get_obs(sel);
    check({tag, "_out_valid"}, 32'(o.out_valid), 32'(0));
    check({tag, "_out_data"}, 32'(o.out_data), 32'(mdl_data[sel]));
  endtask

  task automatic check_all_zero(input string tag);
    obs_t o;
    for (int s = 0; s < N; s++) begin
      o = get_obs(s);
      check({tag, "_flags"}, 32'({o.done, o.parity_err, o.framing_err, o.overrun, o.out_valid}), 32'(0));
      check({tag, "_out_data"}, 32'(o.out_data), 32'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    obs_t o;
    for (int s = 0; s < N; s++) begin
      mdl_valid[s] = 1'b0;
      mdl_data[s]  = '0;
    end
    reset = 1'b0;
    for (int s = 0; s < N; s++) begin
      set_in(s, 1'b1);
      set_ready(s, 1'b0);
    end
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    idle(2);

    send_frame(0, 9'h0A5, 1'b0, -1, 1'b0, "a5");
    consume(0, "a5_consume");

    send_frame(0, 9'h03C, 1'b0, -1, 1'b0, "3c_first");
    send_frame(0, 9'h03C, 1'b0, -1, 1'b0, "3c_second");
    idle(1);
    send_frame(0, 9'h0C3, 1'b0, -1, 1'b0, "c3_overrun");
    send_frame(0, 9'h05A, 1'b0, -1, 1'b1, "swap_on_ready");
    consume(0, "5a_consume");

    send_frame(1, 9'h007, 1'b1, -1, 1'b0, "even_bad");
    send_frame(1, 9'h007, 1'b0, -1, 1'b0, "even_good");
    send_frame(2, 9'h0B4, 1'b1, -1, 1'b0, "odd_bad");
    send_frame(2, 9'h0B4, 1'b0, -1, 1'b0, "odd_good");

    send_frame(0, 9'h055, 1'b0, 0, 1'b0, "stop0");
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1'b0);
      @(negedge clk);
      o = get_obs(0);
      check("err_hold_done", 32'(o.done), 32'(0));
      check("err_hold_framing", 32'(o.framing_err), 32'(0));
    end
    idle(1);
    send_frame(0, 9'h055, 1'b0, -1, 1'b1, "after_err");

    send_frame(3, 9'h1FF, 1'b0, 1, 1'b0, "nine_stop2_bad");
    idle(2);
    send_frame(3, 9'h1FF, 1'b0, -1, 1'b0, "nine_good");
    send_frame(2, 9'h066, 1'b0, 0, 1'b0, "odd_stop1_bad");
    idle(2);

    for (int it = 0; it < 80; it++) begin
      int         sel, bs;
      logic [8:0] d;
      bit         bp, r;
      sel = int'($urandom_range(0, 3));
      d   = 9'($urandom) & 9'((1 << db(sel)) - 1);
      bp  = (pm(sel) != PARITY_NONE) && ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, sb(sel) - 1)) : -1;
      r   = 1'($urandom_range(0, 1));
      send_frame(sel, d, bp, bs, r, "rand");
      if (bs >= 0) idle(2);
      else begin
        case ($urandom_range(0, 2))
          0:       ;
          1:       consume(sel, "rand_consume");
          default: idle(1);
        endcase
      end
    end
    idle(2);

    send_frame(0, 9'h011, 1'b0, -1, 1'b0, "pre_reset");
    set_in(0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1'b1);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    for (int s = 0; s < N; s++) begin
      mdl_valid[s] = 1'b0;
      mdl_data[s]  = '0;
    end
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_in(0, 1'b1);
      @(negedge clk);
      o = get_obs(0);
      check("post_reset_done", 32'(o.done), 32'(0));
    end
    send_frame(0, 9'h081, 1'b0, -1, 1'b0, "81_after_reset");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_receiver_param.md
SERIAL_RECEIVER_PARAM -- requirements
Module: serial_receiver_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal range 1..2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge, one line bit per cycle.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in  input  1  serial line, idle high, LSB-first frames.
REQ-007 SHALL have port done  output  1  one-cycle pulse, frame accepted.
REQ-008 SHALL have port out_data  output  DATA_BITS  received word, held until consumed.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data when high with out_valid.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch, frame dropped.
REQ-012 SHALL have port framing_err  output  1  one-cycle pulse, bad stop bit.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse, good frame lost because buffer full.

Function
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP, DONE and ERROR.
REQ-015 IDLE or DONE with in=0 SHALL go to DATA; with in=1 SHALL go to IDLE, so a start bit directly after a stop bit is accepted.
REQ-016 DATA SHALL shift in one bit per cycle, LSB first, for exactly DATA_BITS cycles, using a bit counter cleared outside DATA.
REQ-017 After DATA SHALL come PARITY (one cycle, PARITY_MODE!=0) or else STOP.
REQ-018 PARITY SHALL register the mismatch: even requires XOR(data,parity bit)=0, odd requires 1.
REQ-019 STOP SHALL sample STOP_BITS cycles; any sample 0 SHALL go to ERROR; the final sample 1 SHALL go to DONE.
REQ-020 ERROR SHALL stay until in=1, then go to IDLE; framing_err SHALL pulse in the first ERROR cycle only.
REQ-021 done SHALL equal 1 exactly while state is DONE, for parity-good and parity-bad frames alike.
REQ-022 A parity-bad frame SHALL pulse parity_err in its DONE cycle and SHALL NOT load out_data.
REQ-023 A parity-good frame SHALL load out_data and set out_valid at the edge entering DONE.
REQ-024 At that edge, if out_valid=1 and out_ready=0, the new word SHALL be dropped, the old word kept, and overrun pulsed in the DONE cycle.
REQ-025 At that edge, out_valid=1 with out_ready=1 SHALL consume the old word and load the new one (no overrun).
REQ-026 Otherwise out_valid SHALL clear on the edge where out_valid=1 and out_ready=1.
REQ-027 out_data SHALL NOT change while out_valid=1 except per REQ-025.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, counter 0, shift register 0, out_data 0, out_valid 0, and done/parity_err/framing_err/overrun 0.
REQ-029 Reset mid-frame SHALL abort the frame with no flag; after deassertion a new start bit SHALL be needed.

Structure
REQ-030 Package serial_rx_pkg SHALL hold the state encoding and the PARITY_NONE/EVEN/ODD constants.
REQ-031 The one-entry output holding register and its overrun logic SHALL be a sub-module serial_rx_out_buf.
REQ-032 Illegal DATA_BITS, PARITY_MODE or STOP_BITS SHALL fail elaboration.

Verification
REQ-033 Defaults, in = 0, then 1,0,1,0,0,1,0,1, then 1 -> done and out_valid high at cycle 10, out_data=0xA5.
REQ-034 Two back-to-back 0x3C frames, out_ready=0 -> second frame's DONE pulses overrun, out_data stays 0x3C.
REQ-035 PARITY_MODE=1, data 0x07, parity bit 0 -> parity_err and done pulse, out_valid stays 0.
REQ-036 Stop bit 0 after 0x55 -> framing_err for one cycle; in held 0 for 5 cycles, no done; in=1 returns to IDLE.
REQ-037 DATA_BITS=9, STOP_BITS=2, data 0x1FF, second stop bit 0 -> ERROR, framing_err, no load.
REQ-038 reset asserted on cycle 4 of DATA -> outputs 0 at once; a following 0x81 frame is received correctly.
